// File: rtl/connect4_pkg.sv
// Shared Connect-4 constants: win direction codes,
// player codes and default board geometry.
package connect4_pkg;

  localparam logic [3:0] DIR_NONE   = 4'd0;
  localparam logic [3:0] DIR_DOWN   = 4'd1;
  localparam logic [3:0] DIR_ROW_1  = 4'd2;
  localparam logic [3:0] DIR_ROW_4  = 4'd5;
  localparam logic [3:0] DIR_RU_1   = 4'd6;
  localparam logic [3:0] DIR_RU_4   = 4'd9;
  localparam logic [3:0] DIR_LD_1   = 4'd10;
  localparam logic [3:0] DIR_LD_4   = 4'd13;
  localparam logic [3:0] NUM_DIRS   = 4'd13;

  localparam logic [1:0] PLAYER_NONE = 2'b00;
  localparam logic [1:0] PLAYER_P1   = 2'b01;
  localparam logic [1:0] PLAYER_P2   = 2'b10;

  localparam int DEF_ROWS    = 6;
  localparam int DEF_COLS    = 7;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/direction_bounds.sv
// Combinational legality test: do all four cells
// of a win direction stay on the board?
module direction_bounds
  import connect4_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
) (
  input  logic [3:0] dir_i,
  input  logic [2:0] row_i,
  input  logic [2:0] col_i,
  output logic       in_bounds_o
);

  localparam logic signed [5:0] ROWS_S = 6'(ROWS);
  localparam logic signed [5:0] COLS_S = 6'(COLS);

  logic signed [5:0] r, c, k;
  logic signed [5:0] rlo, rhi, clo, chi;
  logic        [3:0] off;
  logic              valid;

  // Signed 6-bit span math so edge cells never wrap.
  always_comb begin
    r     = $signed({3'b000, row_i});
    c     = $signed({3'b000, col_i});
    off   = 4'd0;
    k     = 6'sd0;
    rlo   = r;
    rhi   = r;
    clo   = c;
    chi   = c;
    valid = 1'b1;
    unique case (1'b1)
      (dir_i == DIR_DOWN): begin
        rlo = r - 6'sd3;
      end
      (dir_i >= DIR_ROW_1 && dir_i <= DIR_ROW_4): begin
        off = dir_i - DIR_ROW_1;
        k   = $signed({2'b00, off}) + 6'sd1;
        clo = c - 6'sd4 + k;
        chi = c + k - 6'sd1;
      end
      (dir_i >= DIR_RU_1 && dir_i <= DIR_RU_4): begin
        off = dir_i - DIR_RU_1;
        k   = $signed({2'b00, off}) + 6'sd1;
        rlo = r - 6'sd4 + k;
        rhi = r + k - 6'sd1;
        clo = c - 6'sd4 + k;
        chi = c + k - 6'sd1;
      end
      (dir_i >= DIR_LD_1 && dir_i <= DIR_LD_4): begin
        off = dir_i - DIR_LD_1;
        k   = $signed({2'b00, off}) + 6'sd1;
        rlo = r - 6'sd4 + k;
        rhi = r + k - 6'sd1;
        clo = c - k + 6'sd1;
        chi = c + 6'sd4 - k;
      end
      default: valid = 1'b0;
    endcase
    in_bounds_o = valid
                & (rlo >= 6'sd0) & (rhi < ROWS_S)
                & (clo >= 6'sd0) & (chi < COLS_S);
  end

endmodule

// File: rtl/win_check_sequencer.sv
// Walks the 13 win directions after a piece drop,
// runs the direction checker on each legal one.
module win_check_sequencer
  import connect4_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       check_req,
  input  logic [2:0] check_row,
  input  logic [2:0] check_col,
  output logic       busy,
  output logic       dc_start,
  output logic [2:0] dc_row,
  output logic [2:0] dc_col,
  output logic [3:0] dc_direction,
  input  logic       dc_finished,
  input  logic [1:0] dc_winner,
  output logic       done,
  output logic       win_found,
  output logic [1:0] win_player,
  output logic       timeout_err
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EVAL  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [3:0]    dir_q, dir_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    row_q, row_d;
  logic [2:0]    col_q, col_d;
  logic          win_q, win_d;
  logic [1:0]    ply_q, ply_d;
  logic          tmo_q, tmo_d;
  logic          in_bnd;

  direction_bounds #(
    .ROWS(ROWS),
    .COLS(COLS)
  ) u_bounds (
    .dir_i      (dir_q),
    .row_i      (row_q),
    .col_i      (col_q),
    .in_bounds_o(in_bnd)
  );

  assign busy         = (state_q != S_IDLE);
  assign dc_start     = (state_q == S_START);
  assign done         = (state_q == S_FIN);
  assign dc_row       = row_q;
  assign dc_col       = col_q;
  assign dc_direction = dir_q;
  assign win_found    = win_q;
  assign win_player   = ply_q;
  assign timeout_err  = tmo_q;

  // Sequencing FSM: next state, direction and results.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    row_d   = row_q;
    col_d   = col_q;
    win_d   = win_q;
    ply_d   = ply_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (check_req) begin
          row_d   = check_row;
          col_d   = check_col;
          dir_d   = DIR_DOWN;
          win_d   = 1'b0;
          ply_d   = PLAYER_NONE;
          tmo_d   = 1'b0;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (in_bnd) begin
          state_d = S_START;
        end else if (dir_q == NUM_DIRS) begin
          state_d = S_FIN;
        end else begin
          dir_d = dir_q + 4'd1;
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (dc_finished) begin
          if (dc_winner != PLAYER_NONE) begin
            win_d   = 1'b1;
            ply_d   = dc_winner;
            state_d = S_FIN;
          end else if (dir_q == NUM_DIRS) begin
            state_d = S_FIN;
          end else begin
            dir_d   = dir_q + 4'd1;
            state_d = S_EVAL;
          end
        end else if (timer_q == TMAX) begin
          tmo_d   = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset aborts any run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dir_q   <= DIR_NONE;
      timer_q <= '0;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
      win_q   <= 1'b0;
      ply_q   <= PLAYER_NONE;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
      row_q   <= row_d;
      col_q   <= col_d;
      win_q   <= win_d;
      ply_q   <= ply_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule
